// File: rtl/sobel_window_gen.sv
// sobel_window_gen: raster pixel stream to registered 3x3 sobel_matrix windows.
//
// Ports:
//   clk_i, rst_i     clock, asynchronous active-high reset
//   pixel_i          grayscale pixel, accepted when pixel_valid_i=1
//   pixel_valid_i    pixel accept strobe
//   frame_start_i    forces the accepted pixel to position (0,0)
//   matrix_pixels_o  3x3 window, vector0 = top row, pix0 = left column
//   matrix_valid_o   one-cycle pulse per complete in-frame window
//   last_o           (SOBEL_WINDOW_LAST_EN only) final window of the frame
//
// Optional feature macro: SOBEL_WINDOW_LAST_EN adds last_o.

package sobel_pkg;

    localparam int PIXEL_WIDTH_OUT = 8;

    typedef logic [PIXEL_WIDTH_OUT-1:0] sobel_pix_t;

    typedef struct packed {
        sobel_pix_t pix0;
        sobel_pix_t pix1;
        sobel_pix_t pix2;
    } sobel_vector;

    typedef struct packed {
        sobel_vector vector0;
        sobel_vector vector1;
        sobel_vector vector2;
    } sobel_matrix;

endpackage

module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = 16,
    parameter int IMG_HEIGHT = 16,
    parameter int PIX_W      = PIXEL_WIDTH_OUT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [PIX_W-1:0] pixel_i,
    input  logic             pixel_valid_i,
    input  logic             frame_start_i,
    output sobel_matrix      matrix_pixels_o,
    output logic             matrix_valid_o
`ifdef SOBEL_WINDOW_LAST_EN
    ,
    output logic             last_o
`endif
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    // Position of the next pixel to be accepted.
    logic [CW-1:0] col;
    logic [RW-1:0] row;

    // Position the current pixel is actually assigned to.
    logic [CW-1:0] cur_col;
    logic [RW-1:0] cur_row;
    logic [CW-1:0] nxt_col;
    logic [RW-1:0] nxt_row;

    logic accept;
    logic start;
    logic col_wrap;
    logic row_wrap;
    logic qualify;

    // Line buffers: index 0 is the head (oldest), IMG_WIDTH-1 the tail.
    logic [PIX_W-1:0] line1 [IMG_WIDTH];
    logic [PIX_W-1:0] line2 [IMG_WIDTH];

    sobel_matrix win;
    logic        valid_q;

    always_comb begin
        accept   = pixel_valid_i;
        start    = pixel_valid_i & frame_start_i;
        // frame_start_i overrides the counters so a partial frame is dropped.
        cur_col  = start ? '0 : col;
        cur_row  = start ? '0 : row;
        col_wrap = (cur_col == COL_LAST);
        row_wrap = (cur_row == ROW_LAST);
        nxt_col  = col_wrap ? '0 : cur_col + 1'b1;
        nxt_row  = cur_row;
        if (col_wrap) begin
            nxt_row = row_wrap ? '0 : cur_row + 1'b1;
        end
        // Window only complete once two earlier rows and columns exist;
        // the column test also keeps windows from straddling a line wrap.
        qualify  = (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            col <= nxt_col;
            row <= nxt_row;
        end
    end

    // Contents are don't-care after reset; windows are gated by the counters.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            for (int i = 0; i < IMG_WIDTH - 1; i++) begin
                line1[i] <= line1[i+1];
                line2[i] <= line2[i+1];
            end
            line1[IMG_WIDTH-1] <= pixel_i;
            line2[IMG_WIDTH-1] <= line1[0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            win <= '0;
        end else if (accept) begin
            win.vector0.pix0 <= win.vector0.pix1;
            win.vector0.pix1 <= win.vector0.pix2;
            win.vector0.pix2 <= line2[0];
            win.vector1.pix0 <= win.vector1.pix1;
            win.vector1.pix1 <= win.vector1.pix2;
            win.vector1.pix2 <= line1[0];
            win.vector2.pix0 <= win.vector2.pix1;
            win.vector2.pix1 <= win.vector2.pix2;
            win.vector2.pix2 <= pixel_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= accept & qualify;
        end
    end

    assign matrix_pixels_o = win;
    assign matrix_valid_o  = valid_q;

`ifdef SOBEL_WINDOW_LAST_EN
    logic last_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= 1'b0;
        end else begin
            last_q <= accept & col_wrap & row_wrap;
        end
    end

    assign last_o = last_q;
`endif

endmodule
